// File: rtl/tx_ibuf_ctrl.sv
// rtl/tx_ibuf_ctrl.sv - TX internal buffer occupancy controller and read sequencer
module tx_ibuf_ctrl #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_req,
    input  logic [AW:0]   alloc_len,
    output logic          alloc_gnt,
    output logic [AW-1:0] alloc_base,
    input  logic          commit_en,
    input  logic [AW:0]   commit_len,
    input  logic          rd_ready,
    output logic [AW-1:0] dpra,
    output logic          rd_valid,
    output logic [AW:0]   free_qw,
    output logic [AW:0]   avail_qw,
    output logic          ovf_err
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;

    logic [1:0]  state;
    logic [AW:0] len_q;
    logic [AW:0] alloc_ptr;
    logic [AW:0] commit_ptr;
    logic [AW:0] rd_ptr;
    logic        c_en_d1;
    logic        c_en_d2;
    logic [AW:0] c_len_d1;
    logic [AW:0] c_len_d2;
    logic        rd_v1;

    logic        len_bad;
    logic        len_fits;
    logic        commit_bad;
    logic        rd_issue;

    always_comb begin
        len_bad    = (len_q == '0) || (len_q > DEPTH);
        len_fits   = (free_qw >= len_q);
        // Room between commit and alloc pointers, in ring order.
        commit_bad = c_len_d2 > (alloc_ptr - commit_ptr);
        // avail_qw lags a cycle; the live pointer compare stops over-reading.
        rd_issue   = rd_ready && (avail_qw != '0) && (commit_ptr != rd_ptr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            len_q      <= '0;
            alloc_ptr  <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            alloc_gnt  <= 1'b0;
            alloc_base <= '0;
            c_en_d1    <= 1'b0;
            c_en_d2    <= 1'b0;
            c_len_d1   <= '0;
            c_len_d2   <= '0;
            dpra       <= '0;
            rd_v1      <= 1'b0;
            rd_valid   <= 1'b0;
            free_qw    <= DEPTH;
            avail_qw   <= '0;
            ovf_err    <= 1'b0;
        end else begin
            alloc_gnt <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (alloc_req) begin
                        len_q <= alloc_len;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (len_bad) begin
                        state <= S_IDLE;
                    end else if (len_fits) begin
                        alloc_gnt  <= 1'b1;
                        alloc_base <= alloc_ptr[AW-1:0];
                        state      <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    alloc_ptr <= alloc_ptr + len_q;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Two-stage delay matches the buffer write latency.
            c_en_d1  <= commit_en;
            c_len_d1 <= commit_len;
            c_en_d2  <= c_en_d1;
            c_len_d2 <= c_len_d1;
            if (c_en_d2 && !commit_bad) begin
                commit_ptr <= commit_ptr + c_len_d2;
            end

            ovf_err <= ovf_err
                     | ((state == S_CHECK) && len_bad)
                     | (c_en_d2 && commit_bad);

            if (rd_issue) begin
                dpra   <= rd_ptr[AW-1:0];
                rd_ptr <= rd_ptr + ONE;
            end
            rd_v1    <= rd_issue;
            rd_valid <= rd_v1;

            free_qw  <= DEPTH - (alloc_ptr - rd_ptr);
            avail_qw <= commit_ptr - rd_ptr;
        end
    end

endmodule

// File: tb/tb_tx_ibuf_ctrl.sv
// tb/tb_tx_ibuf_ctrl.sv - directed self-checking bench for tx_ibuf_ctrl
module tb_tx_ibuf_ctrl;

    logic        clk;
    logic        reset;
    logic        alloc_req;
    logic [9:0]  alloc_len;
    logic        alloc_gnt;
    logic [8:0]  alloc_base;
    logic        commit_en;
    logic [9:0]  commit_len;
    logic        rd_ready;
    logic [8:0]  dpra;
    logic        rd_valid;
    logic [9:0]  free_qw;
    logic [9:0]  avail_qw;
    logic        ovf_err;

    // buffer model: 2-stage write, registered read
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic        we1, we2;
    logic [8:0]  wa1, wa2;
    logic [63:0] wd1, wd2;
    logic [63:0] mem [512];
    logic [63:0] qdpo;
    logic [8:0]  dpra_d;

    int          errors;
    int          checks;
    int          rd_cnt;
    int          seq;
    logic [8:0]  exp_addr [$];
    logic [63:0] exp_data [$];

    tx_ibuf_ctrl #(.AW(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .alloc_req  (alloc_req),
        .alloc_len  (alloc_len),
        .alloc_gnt  (alloc_gnt),
        .alloc_base (alloc_base),
        .commit_en  (commit_en),
        .commit_len (commit_len),
        .rd_ready   (rd_ready),
        .dpra       (dpra),
        .rd_valid   (rd_valid),
        .free_qw    (free_qw),
        .avail_qw   (avail_qw),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        we1 <= wr_en;
        wa1 <= wr_addr;
        wd1 <= wr_data;
        we2 <= we1;
        wa2 <= wa1;
        wd2 <= wd1;
        if (we2) mem[wa2] <= wd2;
        qdpo   <= mem[dpra];
        dpra_d <= dpra;
    end

    task automatic tick();
        logic [8:0]  ea;
        logic [63:0] ed;
        @(posedge clk);
        #1;
        if (rd_valid) begin
            rd_cnt++;
            checks++;
            if (exp_data.size() == 0) begin
                errors++;
                $display("FAIL rd_extra: got rd_valid=1 expected no pending read");
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (qdpo !== ed || dpra_d !== ea) begin
                    errors++;
                    $display("FAIL rd_data: got addr=%0d data=%h expected addr=%0d data=%h",
                             dpra_d, qdpo, ea, ed);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; alloc_req = 1'b0; commit_en = 1'b0; rd_ready = 1'b0; wr_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic do_alloc(input logic [9:0] len, output logic [8:0] base);
        bit got;
        got = 1'b0;
        base = '0;
        alloc_req = 1'b1;
        alloc_len = len;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (alloc_gnt === 1'b1) begin
                got  = 1'b1;
                base = alloc_base;
            end
        end
        alloc_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL alloc_timeout: got no alloc_gnt expected grant for len=%0d", len);
        end
    endtask

    task automatic write_burst(input logic [8:0] base, input int n, input bit each);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_addr = base + 9'(i);
            wr_data = 64'hD0D0_0000_0000_0000 + 64'(seq);
            seq++;
            exp_addr.push_back(wr_addr);
            exp_data.push_back(wr_data);
            commit_en  = each || (i == n - 1);
            commit_len = each ? 10'd1 : 10'(n);
            tick();
        end
        wr_en = 1'b0;
        commit_en = 1'b0;
    endtask

    task automatic drain(input int bound);
        bit done;
        done = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            done = (free_qw == 10'd512) && (exp_data.size() == 0);
        end
        rd_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got free_qw=%0d pending=%0d expected 512/0",
                     free_qw, exp_data.size());
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (free_qw !== 10'd512 || avail_qw !== 10'd0 || alloc_gnt !== 1'b0 ||
            rd_valid !== 1'b0 || ovf_err !== 1'b0 || dpra !== 9'd0 || alloc_base !== 9'd0) begin
            errors++;
            $display("FAIL %s: got free=%0d avail=%0d gnt=%b rv=%b ovf=%b dpra=%0d base=%0d expected 512/0/0/0/0/0/0",
                     tag, free_qw, avail_qw, alloc_gnt, rd_valid, ovf_err, dpra, alloc_base);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset_values");
    endtask

    task automatic test_basic();
        alloc_req = 1'b1;
        alloc_len = 10'd16;
        tick();
        checks++;
        if (alloc_gnt !== 1'b0) begin
            errors++; $display("FAIL basic_early_gnt: got %b expected 0", alloc_gnt);
        end
        tick();
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_base !== 9'd0) begin
            errors++; $display("FAIL basic_gnt: got gnt=%b base=%0d expected 1/0", alloc_gnt, alloc_base);
        end
        alloc_req = 1'b0;
        tick();
        tick();
        checks++;
        if (free_qw !== 10'd496) begin
            errors++; $display("FAIL basic_free: got %0d expected 496", free_qw);
        end
        write_burst(9'd0, 16, 1'b0);
        tick();
        tick();
        checks++;
        if (avail_qw !== 10'd0) begin
            errors++; $display("FAIL basic_avail_early: got %0d expected 0", avail_qw);
        end
        tick();
        checks++;
        if (avail_qw !== 10'd16) begin
            errors++; $display("FAIL basic_avail: got %0d expected 16", avail_qw);
        end
        rd_ready = 1'b1;
        for (int t = 1; t <= 18; t++) begin
            tick();
            checks++;
            if (dpra !== 9'((t - 1 < 15) ? t - 1 : 15) || rd_valid !== (t >= 2 && t <= 17)) begin
                errors++;
                $display("FAIL basic_stream t=%0d: got dpra=%0d rv=%b expected dpra=%0d rv=%b",
                         t, dpra, rd_valid, (t - 1 < 15) ? t - 1 : 15, (t >= 2 && t <= 17));
            end
        end
        rd_ready = 1'b0;
        tick();
        checks++;
        if (avail_qw !== 10'd0 || free_qw !== 10'd512 || exp_data.size() != 0) begin
            errors++;
            $display("FAIL basic_end: got avail=%0d free=%0d pending=%0d expected 0/512/0",
                     avail_qw, free_qw, exp_data.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] base;
        do_alloc(10'd8, base);
        checks++;
        if (base !== 9'd16) begin
            errors++; $display("FAIL b2b_base: got %0d expected 16", base);
        end
        write_burst(base, 8, 1'b1);
        tick();
        tick();
        tick();
        checks++;
        if (avail_qw !== 10'd8 || ovf_err !== 1'b0) begin
            errors++; $display("FAIL b2b_avail: got avail=%0d ovf=%b expected 8/0", avail_qw, ovf_err);
        end
        drain(40);
    endtask

    task automatic test_fill();
        logic [8:0] base;
        bit         bad;
        bit         got;
        do_reset();
        do_alloc(10'd512, base);
        tick();
        tick();
        checks++;
        if (base !== 9'd0 || free_qw !== 10'd0) begin
            errors++; $display("FAIL fill_full: got base=%0d free=%0d expected 0/0", base, free_qw);
        end
        alloc_req = 1'b1;
        alloc_len = 10'd1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (alloc_gnt !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL fill_wait: got alloc_gnt=1 expected 0 while full");
        end
        write_burst(9'd0, 512, 1'b0);
        for (int i = 0; i < 10 && avail_qw == 10'd0; i++) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (alloc_gnt === 1'b1) begin
                got  = 1'b1;
                base = alloc_base;
            end
        end
        alloc_req = 1'b0;
        checks++;
        if (!got || base !== 9'd0) begin
            errors++; $display("FAIL fill_wrap_gnt: got gnt=%b base=%0d expected 1/0", got, base);
        end
    endtask

    task automatic test_wrap();
        logic [8:0] base;
        int         c0;
        do_reset();
        do_alloc(10'd500, base);
        write_burst(base, 500, 1'b0);
        drain(700);
        do_alloc(10'd20, base);
        checks++;
        if (base !== 9'd500) begin
            errors++; $display("FAIL wrap_base: got %0d expected 500", base);
        end
        c0 = rd_cnt;
        write_burst(base, 20, 1'b0);
        drain(60);
        checks++;
        if (rd_cnt - c0 != 20) begin
            errors++; $display("FAIL wrap_count: got %0d expected 20", rd_cnt - c0);
        end
    endtask

    task automatic test_errors();
        logic [8:0] base;
        bit         bad;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            alloc_req = 1'b1;
            alloc_len = (k == 0) ? 10'd0 : 10'd513;
            bad = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (alloc_gnt !== 1'b0) bad = 1'b1;
            end
            alloc_req = 1'b0;
            checks++;
            if (bad || ovf_err !== 1'b1) begin
                errors++;
                $display("FAIL err_len%0d: got gnt_seen=%b ovf=%b expected 0/1", k, bad, ovf_err);
            end
        end
        do_reset();
        do_alloc(10'd4, base);
        commit_en  = 1'b1;
        commit_len = 10'd8;
        tick();
        commit_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (ovf_err !== 1'b1 || avail_qw !== 10'd0) begin
            errors++;
            $display("FAIL err_commit: got ovf=%b avail=%0d expected 1/0", ovf_err, avail_qw);
        end
    endtask

    task automatic test_toggle();
        logic [8:0] base;
        int         c0;
        do_reset();
        do_alloc(10'd10, base);
        write_burst(base, 10, 1'b0);
        for (int i = 0; i < 10 && avail_qw != 10'd10; i++) tick();
        checks++;
        if (avail_qw !== 10'd10) begin
            errors++; $display("FAIL toggle_avail: got %0d expected 10", avail_qw);
        end
        c0 = rd_cnt;
        for (int i = 0; i < 40; i++) begin
            rd_ready = ~rd_ready;
            tick();
        end
        rd_ready = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (rd_cnt - c0 != 10 || exp_data.size() != 0) begin
            errors++;
            $display("FAIL toggle_count: got %0d pending=%0d expected 10/0", rd_cnt - c0, exp_data.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] base;
        do_alloc(10'd16, base);
        write_burst(base, 16, 1'b0);
        for (int i = 0; i < 10 && avail_qw == 10'd0; i++) tick();
        rd_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++; $display("FAIL mid_streaming: got rd_valid=%b expected 1", rd_valid);
        end
        reset = 1'b1;
        tick();
        check_reset_values("mid_reset_values");
        reset = 1'b0;
        rd_ready = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        tick();
        tick();
        checks++;
        if (rd_valid !== 1'b0 || free_qw !== 10'd512) begin
            errors++; $display("FAIL mid_after: got rv=%b free=%0d expected 0/512", rd_valid, free_qw);
        end
    endtask

    initial begin
        errors = 0; checks = 0; rd_cnt = 0; seq = 0;
        reset = 1'b1; alloc_req = 1'b0; alloc_len = '0; commit_en = 1'b0; commit_len = '0;
        rd_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_fill();
        test_wrap();
        test_errors();
        test_toggle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_ibuf_ctrl.md
Name: tx_ibuf_ctrl

Overview:
- Single-clock occupancy controller and read sequencer for the TX internal buffer, a 2^AW x DW dual-port RAM.
  - Write port latency: 2 cycles, address/data registered before the RAM write.
  - Read port latency: 1 cycle, registered qdpo.
- Sits between the TX DMA request engine, the buffer and the MAC-side streamer. It reserves ring space for outstanding DMA reads, makes written data visible on commit, and drives the buffer read address.

Parameters:
- AW, 9: buffer address width; ring depth is 2^AW qwords.

Ports:
- clk  in  1  clock for all logic; buffer clk and qdpo_clk are tied to it.
- reset  in  1  synchronous, active-high.
- alloc_req  in  1  reservation request; held high until alloc_gnt.
- alloc_len  in  AW+1  qwords to reserve; legal range 1..2^AW; stable while alloc_req is high.
- alloc_gnt  out  1  one-cycle grant pulse.
- alloc_base  out  AW  ring address of the first reserved qword; valid with alloc_gnt.
- commit_en  in  1  in-order commit of the oldest uncommitted qwords.
- commit_len  in  AW+1  qwords committed; sampled with commit_en.
- rd_ready  in  1  streamer can accept one qword.
- dpra  out  AW  buffer read address.
- rd_valid  out  1  buffer qdpo holds a committed qword this cycle.
- free_qw  out  AW+1  unreserved ring space.
- avail_qw  out  AW+1  committed but not yet read qwords.
- ovf_err  out  1  sticky protocol error.

Behaviour:
- Pointers: alloc_ptr, commit_ptr and rd_ptr, each AW+1 bits. The MSB is the wrap bit; the low AW bits address the RAM. Arithmetic is modulo 2^(AW+1).
- Derived counts, all registered:
  - free_qw = 2^AW - (alloc_ptr - rd_ptr)
  - avail_qw = commit_ptr - rd_ptr
- Ordering invariant: rd_ptr <= commit_ptr <= alloc_ptr in ring order.
- Reset values:
  - all pointers 0, dpra 0, alloc_base 0
  - alloc_gnt 0, rd_valid 0, ovf_err 0, avail_qw 0
  - free_qw = 2^AW (not 0)
  - FSM in IDLE; commit delay pipe and read pipe flushed.
  - Reset mid-operation discards all reservations and in-flight reads. rd_valid is 0 on the cycle after reset is asserted.
- Alloc FSM states are IDLE, CHECK and GRANT.
  - IDLE: when alloc_req is high, latch alloc_len and go to CHECK.
  - CHECK, illegal length (0 or greater than 2^AW): set ovf_err, go to IDLE, no grant.
  - CHECK, free_qw >= len: go to GRANT. Otherwise stay in CHECK.
  - GRANT: alloc_gnt=1 and alloc_base=alloc_ptr[AW-1:0] for one cycle; alloc_ptr += len; go to IDLE.
  - Minimum grant latency is 2 cycles after alloc_req is first sampled.
  - If alloc_req is still high in IDLE after a grant, it is a new request.
- Reservations may wrap. The requester writes to (alloc_base + i) mod 2^AW.
- Commit:
  - commit_en/commit_len pass through a 2-stage delay. This covers the buffer write latency, so a commit may coincide with the last data write.
  - On the delayed strobe: if commit_ptr + len exceeds alloc_ptr in ring order, set ovf_err and ignore the commit. Otherwise commit_ptr += len.
  - Back-to-back commits on consecutive cycles are accepted.
- Read issue:
  - In cycle N, if rd_ready and avail_qw > 0: dpra <= rd_ptr[AW-1:0] and rd_ptr++.
  - rd_valid is asserted in cycle N+2, aligned to the buffer's registered qdpo. Sustained rate is 1 qword per cycle.
  - rd_ready low means no issue; in-flight reads still complete.
- Simultaneous events:
  - Grant, delayed commit and read issue may occur in the same cycle. Each uses the previous-cycle pointer values, so free_qw and avail_qw are conservative by one cycle.
  - A slot freed by a read cannot be rewritten before it is read. The earliest reallocated write lands at N+4, after the read at the end of N+1.
- Full: free_qw=0, and CHECK waits. Empty: avail_qw=0, and no read issue.
- ovf_err clears only on reset; normal operation continues after it is set.

Test Plan:
- After reset: alloc_req, len=16 -> alloc_gnt 2 cycles later, alloc_base=0, free_qw=496. Write 16 qwords, commit_en len=16 with the last write -> avail_qw=16 three cycles later. Hold rd_ready -> dpra 0..15, rd_valid for 16 consecutive cycles starting 2 cycles after the first issue, data matches.
- Fill: alloc 512 -> free_qw=0. Next alloc 1 stays in CHECK with no gnt. Commit 512 and read 1 qword -> gnt follows, alloc_base=0 (wrap).
- Wrap: alloc 500, commit and drain all; then alloc 20 -> alloc_base=500. Reads issue dpra 500..511, 0..7 in order.
- Errors: alloc_len=0 -> no gnt, ovf_err=1. Separately, after reset, commit 8 with only 4 reserved -> ovf_err=1, avail_qw stays 0.
- Toggle rd_ready every other cycle with avail 10 -> exactly 10 rd_valid pulses, no duplicates. Reset asserted mid-stream -> all outputs return to reset values next cycle, free_qw=512.
